// File: rtl/i2c_master_cmd_engine.sv
// Byte-level I2C master: executes one START/STOP/READ/WRITE command at a time.
// Define I2C_CLOCK_STRETCH_EN to honour slave SCL stretching in data/ack slots.
module i2c_master_cmd_engine #(
  parameter int QUARTER_CYCLES = 32,
  parameter int CNT_W = $clog2(QUARTER_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_received,
  output logic       busy,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       scl_i,
  output logic       scl_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STOP,
    S_BIT,
    S_ACK,
    S_DONE
  } state_e;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_WRITE = 2'd3;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(QUARTER_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [7:0]       wr_q, wr_d;
  logic             rdack_q, rdack_d;
  logic [7:0]       sr_q, sr_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             ack_q, ack_d;
  logic             sda_oe_q, sda_oe_d;
  logic             scl_oe_q, scl_oe_d;

  logic active;
  logic stall;
  logic q_last;
  logic slot_end;
  logic sample;

  assign active = (state_q == S_START) ||
                  (state_q == S_STOP)  ||
                  (state_q == S_BIT)   ||
                  (state_q == S_ACK);

`ifdef I2C_CLOCK_STRETCH_EN
  // Slave holds SCL low while we release it in the high phase.
  assign stall = ((state_q == S_BIT) ||
                  (state_q == S_ACK)) &&
                 !scl_oe_q && !scl_i &&
                 ((qtr_q == 2'd1) || (qtr_q == 2'd2));
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall = 1'b0;
`endif

  assign q_last   = (cnt_q == LAST);
  assign slot_end = active && !stall && q_last &&
                    (qtr_q == 2'd3);
  assign sample   = active && !stall &&
                    (qtr_q == 2'd2) &&
                    (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    wr_d      = wr_q;
    rdack_d   = rdack_q;
    sr_d      = sr_q;
    rd_data_d = rd_data_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    scl_oe_d  = scl_oe_q;

    if (active && !stall) begin
      if (q_last) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          wr_d    = wr_data;
          rdack_d = rd_ack;
          cnt_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd7;
          unique case (1'b1)
            cmd == C_START: state_d = S_START;
            cmd == C_STOP:  state_d = S_STOP;
            default:        state_d = S_BIT;
          endcase
        end
      end
      S_START, S_STOP: begin
        if (slot_end) state_d = S_DONE;
      end
      S_BIT: begin
        if (sample && cmd_q == C_READ)
          sr_d = {sr_q[6:0], sda_i};
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = S_ACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      S_ACK: begin
        if (sample && cmd_q == C_WRITE)
          ack_d = ~sda_i;
        if (slot_end) begin
          state_d = S_DONE;
          if (cmd_q == C_READ) rd_data_d = sr_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line levels follow the quarter being entered; IDLE/DONE hold.
    unique case (state_d)
      S_START: begin
        sda_oe_d = (qtr_d != 2'd0);
        scl_oe_d = qtr_d[1];
      end
      S_STOP: begin
        sda_oe_d = !qtr_d[1];
        scl_oe_d = (qtr_d == 2'd0);
      end
      S_BIT: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = (cmd_d == C_WRITE) ? ~wr_d[bit_d] : 1'b0;
      end
      S_ACK: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = (cmd_d == C_WRITE) ? 1'b0 : rdack_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      cmd_q     <= C_START;
      wr_q      <= 8'h00;
      rdack_q   <= 1'b0;
      sr_q      <= 8'h00;
      rd_data_q <= 8'h00;
      ack_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      wr_q      <= wr_d;
      rdack_q   <= rdack_d;
      sr_q      <= sr_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      sda_oe_q  <= sda_oe_d;
      scl_oe_q  <= scl_oe_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign rsp_valid    = (state_q == S_DONE);
  assign rd_data      = rd_data_q;
  assign ack_received = ack_q;
  assign sda_oe       = sda_oe_q;
  assign scl_oe       = scl_oe_q;

endmodule

// File: tb/tb_i2c_master_cmd_engine.sv
// Bench for i2c_master_cmd_engine: per-cycle waveform model built from
// quarter tables, open-drain bus with a scripted slave, random commands.
module tb_i2c_master_cmd_engine;

  localparam int QC  = 4;
  localparam int STR = 50;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STR_DLY = STR;
`else
  localparam int STR_DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_ack;
  logic       rsp_valid;
  logic [7:0] rd_data;
  logic       ack_received;
  logic       busy;
  logic       sda_i;
  logic       sda_oe;
  logic       scl_i;
  logic       scl_oe;

  logic slv_pull = 1'b0;
  logic slv_str = 1'b0;

  assign sda_i = ~(sda_oe | slv_pull);
  assign scl_i = ~(scl_oe | slv_str);

  i2c_master_cmd_engine #(
    .QUARTER_CYCLES(QC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd(cmd),
    .wr_data(wr_data),
    .rd_ack(rd_ack),
    .rsp_valid(rsp_valid),
    .rd_data(rd_data),
    .ack_received(ack_received),
    .busy(busy),
    .sda_i(sda_i),
    .sda_oe(sda_oe),
    .scl_i(scl_i),
    .scl_oe(scl_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       sda;
    bit       scl;
    bit       rsp;
    bit       slv;
    bit       str;
    bit       rd;
    bit       wr;
    bit [7:0] rdv;
    bit       ackv;
  } ent_t;

  ent_t     exp_q[$];
  int       vec = 0;
  int       bad = 0;
  int       cyc = 0;
  int       acc_cyc = 0;
  int       lat = 0;
  int       str_left = 0;
  bit       last_sda;
  bit       last_scl;
  bit [7:0] exp_rd;
  bit       exp_ack;
  bit       bsda;
  bit       bscl;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    last_sda = 1'b0;
    last_scl = 1'b0;
    exp_rd   = 8'h00;
    exp_ack  = 1'b0;
    slv_pull = 1'b0;
    slv_str  = 1'b0;
  endfunction

  function automatic void push(bit sda, bit scl, bit slv,
                               int n, bit fstr);
    for (int k = 0; k < n; k++) begin
      ent_t e;
      e = '{default: 0};
      e.sda = sda;
      e.scl = scl;
      e.slv = slv;
      e.str = fstr || (str_left > 0);
      if (!fstr && str_left > 0) str_left--;
      exp_q.push_back(e);
    end
    bsda = sda;
    bscl = scl;
  endfunction

  // One bit slot: SCL low in Q0/Q3, released in Q1/Q2.
  function automatic void slot(bit sda, bit slv, bit st);
    push(sda, 1'b1, slv, QC, 1'b0);
    if (st) begin
`ifdef I2C_CLOCK_STRETCH_EN
      push(sda, 1'b0, slv, STR, 1'b1);
`else
      str_left = STR;
`endif
    end
    push(sda, 1'b0, slv, 2 * QC, 1'b0);
    push(sda, 1'b1, slv, QC, 1'b0);
  endfunction

  function automatic void build(int c, bit [7:0] w, bit ra,
                                bit [7:0] sb, bit sa, int sbit);
    ent_t e;
    str_left = 0;
    if (c == 0) begin
      push(1'b0, 1'b0, 1'b0, QC, 1'b0);
      push(1'b1, 1'b0, 1'b0, QC, 1'b0);
      push(1'b1, 1'b1, 1'b0, 2 * QC, 1'b0);
    end else if (c == 1) begin
      push(1'b1, 1'b1, 1'b0, QC, 1'b0);
      push(1'b1, 1'b0, 1'b0, QC, 1'b0);
      push(1'b0, 1'b0, 1'b0, 2 * QC, 1'b0);
    end else begin
      for (int i = 7; i >= 0; i--)
        slot((c == 3) ? !w[i] : 1'b0,
             (c == 2) ? !sb[i] : 1'b0,
             i == sbit);
      if (c == 3) slot(1'b0, sa, 1'b0);
      else slot(ra, 1'b0, 1'b0);
    end
    e = '{default: 0};
    e.sda  = bsda;
    e.scl  = bscl;
    e.rsp  = 1'b1;
    e.rd   = (c == 2);
    e.rdv  = sb;
    e.wr   = (c == 3);
    e.ackv = sa;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    ent_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      slv_pull = e.slv;
      slv_str  = e.str;
      chk("sda_oe", int'(sda_oe), int'(e.sda));
      chk("scl_oe", int'(scl_oe), int'(e.scl));
      chk("rsp_valid", int'(rsp_valid), int'(e.rsp));
      chk("cmd_ready_busy", int'(cmd_ready), 0);
      chk("busy", int'(busy), 1);
      last_sda = e.sda;
      last_scl = e.scl;
      if (e.rsp) begin
        if (e.rd) exp_rd = e.rdv;
        if (e.wr) exp_ack = e.ackv;
        lat = cyc - acc_cyc + 1;
        chk("rd_data_rsp", int'(rd_data), int'(exp_rd));
        chk("ack_rsp", int'(ack_received), int'(exp_ack));
      end
    end else begin
      slv_pull = 1'b0;
      slv_str  = 1'b0;
      chk("idle_ready", int'(cmd_ready), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_rsp", int'(rsp_valid), 0);
      chk("idle_sda", int'(sda_oe), int'(last_sda));
      chk("idle_scl", int'(scl_oe), int'(last_scl));
      chk("idle_rd", int'(rd_data), int'(exp_rd));
      chk("idle_ack", int'(ack_received), int'(exp_ack));
    end
  end

  task automatic send(int c, bit [7:0] w, bit ra,
                      bit [7:0] sb, bit sa, int sbit);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", int'(cmd_ready), 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd       = c[1:0];
    wr_data   = w;
    rd_ack    = ra;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    build(c, w, ra, sb, sa, sbit);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom);
    wr_data   = 8'($urandom);
    rd_ack    = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic run(int c, bit [7:0] w, bit ra,
                     bit [7:0] sb, bit sa, int sbit);
    send(c, w, ra, sb, sa, sbit);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cmd     = 2'd0;
    wr_data = 8'h00;
    rd_ack  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    run(0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    chk("start_lat", lat, 17);

    run(3, 8'h78, 1'b0, 8'h00, 1'b1, -1);
    chk("wr78_lat", lat, 145);
    chk("wr78_ack", int'(ack_received), 1);

    run(3, 8'h3C, 1'b0, 8'h00, 1'b0, -1);
    chk("wr3c_ack", int'(ack_received), 0);
    chk("wr3c_ready", int'(cmd_ready), 1);

    run(2, 8'h00, 1'b0, 8'hA5, 1'b0, -1);
    chk("rd_a5", int'(rd_data), 8'hA5);

    run(1, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    chk("stop_sda", int'(sda_oe), 0);
    chk("stop_scl", int'(scl_oe), 0);

    run(2, 8'h00, 1'b1, 8'h3C, 1'b0, 3);
    chk("str_lat", lat, 145 + STR_DLY);
    chk("str_rd", int'(rd_data), 8'h3C);

    for (int t = 0; t < 12; t++) begin
      int c;
      int sb;
      c  = $urandom_range(0, 3);
      sb = ($urandom_range(0, 3) == 0) ?
           $urandom_range(0, 7) : -1;
      run(c, 8'($urandom), 1'($urandom),
          8'($urandom), 1'($urandom), sb);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    send(3, 8'h5A, 1'b0, 8'h00, 1'b1, -1);
    repeat (44) @(posedge clk);
    #2;
    chk("pre_rst_sda", int'(sda_oe), 1);
    chk("pre_rst_scl", int'(scl_oe), 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_sda", int'(sda_oe), 0);
    chk("rst_scl", int'(scl_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run(0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    chk("start2_lat", lat, 17);
    chk("start2_sda", int'(sda_oe), 1);
    chk("start2_scl", int'(scl_oe), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_cmd_engine.md
Name: i2c_master_cmd_engine

Overview:
Parametrised byte-level I2C master that executes one bus command at a time: START, STOP, WRITE byte, READ byte. It replaces the fixed-timing, write-only, hard-wired sequencer. It adds a valid/ready command port, a response channel, read support with master ACK/NACK, slave ACK capture, and a programmable SCL rate. A higher-level sequencer (e.g. OLED init) sits above it and drives commands. Open-drain pads sit below it.

Parameters:
QUARTER_CYCLES, 32, clk cycles per SCL quarter-period; legal range 2 or more. SCL period = 4*QUARTER_CYCLES.
CNT_W, $clog2(QUARTER_CYCLES), width of the quarter counter.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  engine can accept a command
cmd  input  2  0=START, 1=STOP, 2=READ, 3=WRITE
wr_data  input  8  byte for WRITE; latched on acceptance
rd_ack  input  1  READ only: 1=master ACKs (SDA low), 0=NACK; latched on acceptance
rsp_valid  output  1  one-cycle pulse when a command completes
rd_data  output  8  received byte; valid with rsp_valid after READ
ack_received  output  1  after WRITE: 1 = slave pulled SDA low in the ACK slot; held until the next WRITE completes
busy  output  1  command in progress
sda_i  input  1  SDA pad level
sda_oe  output  1  1 = drive SDA low, 0 = release
scl_i  input  1  SCL pad level
scl_oe  output  1  1 = drive SCL low, 0 = release

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state IDLE; sda_oe=0, scl_oe=0 (bus released immediately).
  - cmd_ready=1, rsp_valid=0, rd_data=0, ack_received=0, busy=0.
- Reset mid-command: the command is aborted and no rsp_valid is produced. The slave is left mid-byte; the upper layer issues START/STOP to recover.
- Handshake:
  - Accept on cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE; cmd_ready=0 and busy=1 from the cycle after acceptance until the rsp_valid cycle.
  - cmd_ready returns to 1 the cycle after rsp_valid. Back-to-back acceptance is therefore possible once per command.
- Quarter counter:
  - Counts 0..QUARTER_CYCLES-1, then advances the quarter index Q0→Q1→Q2→Q3.
  - Counter and quarter index reset to 0 on acceptance.
- States: IDLE, START, STOP, BIT, ACK, DONE.
- START, 4 quarters: Q0 sda_oe=0, scl_oe=0; Q1 sda_oe=1; Q2 scl_oe=1; Q3 hold. Then DONE.
- STOP, 4 quarters: Q0 scl_oe=1, sda_oe=1; Q1 scl_oe=0; Q2 sda_oe=0; Q3 hold. Then DONE.
- BIT, 8 iterations, MSB first, bit index 7 down to 0:
  - Q0: scl_oe=1; sda_oe updated at the Q0 start. For WRITE, sda_oe = ~wr_data[idx]. For READ, sda_oe=0.
  - Q1, Q2: scl_oe=0.
  - Q3: scl_oe=1.
  - READ: sda_i is sampled into a shift register on the first cycle of Q2.
  - After bit 0 Q3, go to ACK.
- ACK, one bit slot with the same quarter timing:
  - WRITE: sda_oe=0; on the first cycle of Q2, ack_received <= ~sda_i.
  - READ: sda_oe=rd_ack.
  - Then DONE.
- DONE, one cycle:
  - rsp_valid=1; rd_data updated (READ only).
  - Then IDLE.
- Line levels between commands: sda_oe and scl_oe hold their last values in IDLE. After START/WRITE/READ, SCL stays held low; after STOP, both lines are released.
- Latency, acceptance to rsp_valid: START/STOP = 4*QUARTER_CYCLES+1 cycles; WRITE/READ = 36*QUARTER_CYCLES+1 cycles, without stretching.
- cmd/wr_data/rd_ack changes while busy are ignored.

Optional Feature:
I2C_CLOCK_STRETCH_EN
- Defined: in BIT and ACK, when scl_oe=0 and scl_i=0 (slave stretching) during Q1 or Q2, the quarter counter freezes. Counting resumes the cycle after scl_i is seen high. Sampling happens in the first Q2 cycle after release. Latency grows by the stretch length.
- Undefined: scl_i is unused and timing is fixed.

Test Plan:
- Reset, then START with QUARTER_CYCLES=4 → sda_oe rises at quarter 1 and scl_oe at quarter 2; rsp_valid pulses once at cycle 17; cmd_ready=1 on cycle 18.
- WRITE 0x78, slave model drives SDA low in the ACK slot → sda_oe sequence per bit is ~0,1,1,1,1,0,0,0; ack_received=1; rsp_valid at cycle 36*Q+1.
- WRITE 0x3C with no slave (SDA pulled up) → ack_received=0, rsp_valid still asserted, engine returns to IDLE.
- READ with rd_ack=0, slave returns 0xA5 → rd_data=0xA5 with rsp_valid; sda_oe=0 through all 9 slots; then STOP releases both lines.
- With I2C_CLOCK_STRETCH_EN: slave holds scl_i low for 50 cycles in bit 3 → completion is delayed by exactly 50 cycles and data is still correct; without the macro, latency is unchanged.
- Assert rst_n=0 in the middle of bit 5 of a WRITE → sda_oe=0 and scl_oe=0 in the same cycle; no rsp_valid; after release, cmd_ready=1 and a new START executes normally.
